// File: rtl/buffer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : buffer_arbiter
// Description : Two-port round-robin arbiter and sequencer for the single-port
//               byte/word-addressable 64-bit scratch buffer. Port 0 is the
//               loader, port 1 the compute engine. One access at a time:
//               IDLE (arbitrate) -> ISSUE (drive buffer) -> RESP (reads only).
// Revision    : 1.0 - initial release
// ============================================================================
module buffer_arbiter #(
  parameter int BuffDepth = 256,
  parameter int ByteAddrW = $clog2(BuffDepth),
  parameter int WordDepth = BuffDepth / 8,
  parameter int WordAddrW = $clog2(WordDepth)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic                 req0_we,
  input  logic                 req0_mode,
  input  logic [ByteAddrW-1:0] req0_addr,
  input  logic [63:0]          req0_wdata,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic                 req1_we,
  input  logic                 req1_mode,
  input  logic [ByteAddrW-1:0] req1_addr,
  input  logic [63:0]          req1_wdata,
  output logic                 rsp0_valid,
  output logic [63:0]          rsp0_rdata,
  output logic                 rsp1_valid,
  output logic [63:0]          rsp1_rdata,
  output logic                 buf_write_en,
  output logic                 buf_read_en,
  output logic                 buf_addr_mode,
  output logic [ByteAddrW-1:0] buf_byte_addr,
  output logic [WordAddrW-1:0] buf_word_addr,
  output logic [7:0]           buf_byte_in,
  output logic [63:0]          buf_word_in,
  input  logic [63:0]          buf_word_out,
  output logic                 busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic                   last_grant_q, last_grant_d;

  // Latched request; these registers also drive the buffer pins directly so
  // address/data hold their last values outside ISSUE.
  logic                   we_q, mode_q, port_q;
  logic [ByteAddrW-1:0]   addr_q;
  logic [63:0]            wdata_q;

  // Per-port response data, held between response pulses.
  logic [63:0]            hold0_q, hold1_q;

  logic                   accept;
  logic                   grant_port;
  logic                   acc_we, acc_mode;
  logic [ByteAddrW-1:0]   acc_addr;
  logic [63:0]            acc_wdata;
  logic [63:0]            rsp_word;

  // Buffer read word is registered inside the buffer, so it is valid in RESP;
  // byte reads pick the lane selected by the latched low address bits.
  assign rsp_word = mode_q ? buf_word_out
                           : {56'h0, buf_word_out[{addr_q[2:0], 3'b000} +: 8]};

  // Request fields of the winning port.
  assign acc_we    = grant_port ? req1_we    : req0_we;
  assign acc_mode  = grant_port ? req1_mode  : req0_mode;
  assign acc_addr  = grant_port ? req1_addr  : req0_addr;
  assign acc_wdata = grant_port ? req1_wdata : req0_wdata;

  assign buf_addr_mode = mode_q;
  assign buf_byte_addr = addr_q;
  assign buf_word_addr = addr_q[ByteAddrW-1:3];
  assign buf_byte_in   = wdata_q[7:0];
  assign buf_word_in   = wdata_q;

  // Next-state, arbitration and strobe/response decode.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    accept       = 1'b0;
    grant_port   = 1'b0;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    buf_write_en = 1'b0;
    buf_read_en  = 1'b0;
    rsp0_valid   = 1'b0;
    rsp1_valid   = 1'b0;
    rsp0_rdata   = hold0_q;
    rsp1_rdata   = hold1_q;
    busy         = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        // On a tie the port that did not win last time goes first.
        if (req0_valid && (!req1_valid || last_grant_q)) begin
          req0_ready = 1'b1;
          accept     = 1'b1;
          grant_port = 1'b0;
        end else if (req1_valid) begin
          req1_ready = 1'b1;
          accept     = 1'b1;
          grant_port = 1'b1;
        end
        if (accept) begin
          last_grant_d = grant_port;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        buf_write_en = we_q;
        buf_read_en  = !we_q;
        state_d      = we_q ? ST_IDLE : ST_RESP;
      end
      ST_RESP: begin
        if (port_q) begin
          rsp1_valid = 1'b1;
          rsp1_rdata = rsp_word;
        end else begin
          rsp0_valid = 1'b1;
          rsp0_rdata = rsp_word;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and round-robin pointer; reset favours port 0 on the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Capture the winning request at accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      mode_q  <= 1'b0;
      port_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= acc_we;
      mode_q  <= acc_mode;
      port_q  <= grant_port;
      addr_q  <= acc_addr;
      wdata_q <= acc_wdata;
    end
  end

  // Keep the last delivered response word per port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold0_q <= '0;
      hold1_q <= '0;
    end else if (state_q == ST_RESP) begin
      if (port_q) hold1_q <= rsp_word;
      else        hold0_q <= rsp_word;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_buffer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_buffer_arbiter
// Description : Self-checking bench for buffer_arbiter with a behavioural
//               scratch buffer and a response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_buffer_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_we, req0_mode;
  logic [7:0]  req0_addr;
  logic [63:0] req0_wdata;
  logic        req1_valid, req1_ready, req1_we, req1_mode;
  logic [7:0]  req1_addr;
  logic [63:0] req1_wdata;
  logic        rsp0_valid, rsp1_valid;
  logic [63:0] rsp0_rdata, rsp1_rdata;
  logic        buf_write_en, buf_read_en, buf_addr_mode;
  logic [7:0]  buf_byte_addr;
  logic [4:0]  buf_word_addr;
  logic [7:0]  buf_byte_in;
  logic [63:0] buf_word_in;
  logic [63:0] buf_word_out;
  logic        busy;

  buffer_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_mode(req0_mode), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_mode(req1_mode), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .buf_write_en(buf_write_en), .buf_read_en(buf_read_en),
    .buf_addr_mode(buf_addr_mode), .buf_byte_addr(buf_byte_addr),
    .buf_word_addr(buf_word_addr), .buf_byte_in(buf_byte_in),
    .buf_word_in(buf_word_in), .buf_word_out(buf_word_out), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural scratch buffer: little-endian bytes, registered read word.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (buf_write_en) begin
      if (buf_addr_mode)
        for (int k = 0; k < 8; k++) mem[{buf_word_addr, 3'(k)}] <= buf_word_in[8*k +: 8];
      else
        mem[buf_byte_addr] <= buf_byte_in;
    end
    if (buf_read_en)
      for (int k = 0; k < 8; k++) buf_word_out[8*k +: 8] <= mem[{buf_word_addr, 3'(k)}];
  end

  typedef struct {
    bit          port;
    logic [63:0] data;
    int          cyc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] ref_mem [256];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;

  function automatic logic [63:0] exp_read(input bit mode, input logic [7:0] addr);
    logic [63:0] d;
    d = '0;
    if (mode) for (int k = 0; k < 8; k++) d[8*k +: 8] = ref_mem[{addr[7:3], 3'(k)}];
    else      d = {56'h0, ref_mem[addr]};
    return d;
  endfunction

  // Advance one clock and check responses against the scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    n_checks++;
    if (buf_write_en === 1'b1 && buf_read_en === 1'b1) begin
      n_fail++;
      $display("FAIL strobe_overlap: write_en=%b read_en=%b, required not both high", buf_write_en, buf_read_en);
    end
    if (rsp0_valid === 1'b1 || rsp1_valid === 1'b1) begin
      n_checks++;
      if (rsp0_valid === 1'b1 && rsp1_valid === 1'b1) begin
        n_fail++;
        $display("FAIL rsp_both: rsp0_valid=1 rsp1_valid=1 at cycle %0d, required one port only", cyc);
      end else if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected: rsp0_valid=%b rsp1_valid=%b at cycle %0d, required none", rsp0_valid, rsp1_valid, cyc);
      end else begin
        e = sb.pop_front();
        if (rsp1_valid !== e.port) begin
          n_fail++;
          $display("FAIL rsp_port: got port %0d, required %0d", rsp1_valid, e.port);
        end
        n_checks++;
        if ((e.port ? rsp1_rdata : rsp0_rdata) !== e.data) begin
          n_fail++;
          $display("FAIL rsp_data: got %h, required %h", (e.port ? rsp1_rdata : rsp0_rdata), e.data);
        end
        n_checks++;
        if (cyc !== e.cyc) begin
          n_fail++;
          $display("FAIL rsp_latency: got cycle %0d, required %0d", cyc, e.cyc);
        end
      end
    end
  endtask

  task automatic set_req(input bit port, input bit v, input bit we, input bit mode,
                         input logic [7:0] addr, input logic [63:0] wdata);
    if (port) begin
      req1_valid = v; req1_we = we; req1_mode = mode; req1_addr = addr; req1_wdata = wdata;
    end else begin
      req0_valid = v; req0_we = we; req0_mode = mode; req0_addr = addr; req0_wdata = wdata;
    end
  endtask

  // Record an accepted request in the reference memory / scoreboard.
  task automatic on_accept(input bit port, input bit we, input bit mode,
                           input logic [7:0] addr, input logic [63:0] wdata, input bit expect_rsp);
    exp_t e;
    if (we) begin
      if (mode) for (int k = 0; k < 8; k++) ref_mem[{addr[7:3], 3'(k)}] = wdata[8*k +: 8];
      else      ref_mem[addr] = wdata[7:0];
    end else if (expect_rsp) begin
      e.port = port; e.data = exp_read(mode, addr); e.cyc = cyc + 2;
      sb.push_back(e);
    end
  endtask

  // Present a request until accepted; returns during the ISSUE cycle.
  task automatic issue(input bit port, input bit we, input bit mode,
                       input logic [7:0] addr, input logic [63:0] wdata, input bit expect_rsp);
    bit got;
    got = 0;
    set_req(port, 1'b1, we, mode, addr, wdata);
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if ((port ? req1_ready : req0_ready) === 1'b1) begin
        got = 1;
        on_accept(port, we, mode, addr, wdata, expect_rsp);
      end
      tick();
    end
    set_req(port, 1'b0, 1'b0, 1'b0, 8'h00, 64'h0);
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL accept_timeout: port %0d ready never seen, required accept", port);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL rsp_missing: %0d responses outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_req(0, 0, 0, 0, 8'h00, 64'h0);
    set_req(1, 0, 0, 0, 8'h00, 64'h0);
    tick(); tick();
    n_checks++;
    if ({buf_write_en, buf_read_en, busy, rsp0_valid, rsp1_valid} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: we/re/busy/rv0/rv1=%b, required 00000",
               {buf_write_en, buf_read_en, busy, rsp0_valid, rsp1_valid});
    end
    n_checks++;
    if ({buf_addr_mode, buf_byte_addr, buf_word_addr, buf_byte_in, buf_word_in} !== '0) begin
      n_fail++;
      $display("FAIL reset_buf: mode=%b baddr=%h waddr=%h bin=%h win=%h, required all 0",
               buf_addr_mode, buf_byte_addr, buf_word_addr, buf_byte_in, buf_word_in);
    end
    n_checks++;
    if ({rsp0_rdata, rsp1_rdata} !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_rdata: rdata0=%h rdata1=%h, required 0", rsp0_rdata, rsp1_rdata);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({buf_write_en, buf_read_en, busy} !== 3'b0) begin
        n_fail++;
        $display("FAIL idle_quiet: we/re/busy=%b, required 000", {buf_write_en, buf_read_en, busy});
      end
    end
  endtask

  task automatic test_word_port0();
    issue(0, 1, 1, 8'h10, 64'h0123456789ABCDEF, 0);
    n_checks++;
    if ({buf_write_en, buf_read_en, buf_addr_mode, buf_word_addr, busy} !== {3'b101, 5'd2, 1'b1}) begin
      n_fail++;
      $display("FAIL word_wr_issue: we=%b re=%b mode=%b waddr=%0d busy=%b, required 1 0 1 2 1",
               buf_write_en, buf_read_en, buf_addr_mode, buf_word_addr, busy);
    end
    n_checks++;
    if (buf_word_in !== 64'h0123456789ABCDEF) begin
      n_fail++;
      $display("FAIL word_wr_data: got %h, required 0123456789abcdef", buf_word_in);
    end
    tick();
    issue(0, 0, 1, 8'h10, 64'h0, 1);
    n_checks++;
    if ({buf_write_en, buf_read_en, buf_word_addr} !== {2'b01, 5'd2}) begin
      n_fail++;
      $display("FAIL word_rd_issue: we=%b re=%b waddr=%0d, required 0 1 2",
               buf_write_en, buf_read_en, buf_word_addr);
    end
    drain();
  endtask

  task automatic test_byte_port1();
    issue(1, 1, 0, 8'h13, 64'hFFFF_FFFF_FFFF_FF5A, 0);
    n_checks++;
    if ({buf_write_en, buf_addr_mode, buf_byte_addr, buf_byte_in} !== {2'b10, 8'h13, 8'h5A}) begin
      n_fail++;
      $display("FAIL byte_wr_issue: we=%b mode=%b baddr=%h bin=%h, required 1 0 13 5a",
               buf_write_en, buf_addr_mode, buf_byte_addr, buf_byte_in);
    end
    tick();
    issue(1, 0, 0, 8'h13, 64'h0, 1);
    drain();
    issue(1, 0, 1, 8'h10, 64'h0, 1);
    drain();
    tick();
    n_checks++;
    if (rsp1_valid !== 1'b0 || rsp1_rdata !== 64'h01234567_5AABCDEF) begin
      n_fail++;
      $display("FAIL rdata1_hold: valid=%b rdata=%h, required 0 012345675aabcdef", rsp1_valid, rsp1_rdata);
    end
    n_checks++;
    if (rsp0_rdata !== 64'h0123456789ABCDEF) begin
      n_fail++;
      $display("FAIL rdata0_hold: got %h, required 0123456789abcdef", rsp0_rdata);
    end
  endtask

  task automatic test_contention();
    int grants;
    grants = 0;
    set_req(0, 1, 0, 1, 8'h10, 64'h0);
    set_req(1, 1, 0, 0, 8'h13, 64'h0);
    for (int i = 0; i < 40 && grants < 6; i++) begin
      #1;
      if (req0_ready === 1'b1 && req1_ready === 1'b1) begin
        n_checks++; n_fail++;
        $display("FAIL ready_both: both ports ready, required one");
      end else if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
        n_checks++;
        if (req1_ready !== grants[0]) begin
          n_fail++;
          $display("FAIL grant_order: grant %0d to port %0d, required port %0d", grants, req1_ready, grants[0]);
        end
        if (req1_ready === 1'b1) on_accept(1, 0, 0, 8'h13, 64'h0, 1);
        else                     on_accept(0, 0, 1, 8'h10, 64'h0, 1);
        grants++;
      end
      tick();
    end
    set_req(0, 0, 0, 0, 8'h00, 64'h0);
    set_req(1, 0, 0, 0, 8'h00, 64'h0);
    n_checks++;
    if (grants != 6) begin
      n_fail++;
      $display("FAIL contention_grants: got %0d grants, required 6", grants);
    end
    drain();
  endtask

  task automatic test_reset_mid_read();
    exp_t e;
    issue(0, 0, 1, 8'h10, 64'h0, 0);
    n_checks++;
    if (buf_read_en !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_issue: read_en=%b, required 1", buf_read_en);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++;
    if ({rsp0_valid, busy} !== 2'b00 || rsp0_rdata !== 64'h0) begin
      n_fail++;
      $display("FAIL midrst_state: rsp0_valid=%b busy=%b rdata0=%h, required 0 0 0", rsp0_valid, busy, rsp0_rdata);
    end
    tick(); tick(); tick();
    set_req(0, 1, 0, 1, 8'h10, 64'h0);
    set_req(1, 1, 0, 0, 8'h13, 64'h0);
    #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL midrst_tie: ready0=%b ready1=%b, required 1 0", req0_ready, req1_ready);
    end
    if (req0_ready === 1'b1) on_accept(0, 0, 1, 8'h10, 64'h0, 1);
    if (req1_ready === 1'b1) begin
      e.port = 1; e.data = exp_read(0, 8'h13); e.cyc = cyc + 2;
      sb.push_back(e);
    end
    tick();
    set_req(0, 0, 0, 0, 8'h00, 64'h0);
    set_req(1, 0, 0, 0, 8'h00, 64'h0);
    drain();
  endtask

  task automatic test_withdrawn();
    issue(0, 1, 0, 8'h20, 64'h0000_0000_0000_00A5, 0);
    set_req(1, 1, 1, 1, 8'h40, 64'hDEAD_BEEF_DEAD_BEEF);
    #1;
    n_checks++;
    if (req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_holdoff: ready1=%b while busy, required 0", req1_ready);
    end
    tick();
    set_req(1, 0, 0, 0, 8'h00, 64'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if ({buf_write_en, buf_read_en, busy} !== 3'b0) begin
        n_fail++;
        $display("FAIL withdrawn_access: we/re/busy=%b, required 000", {buf_write_en, buf_read_en, busy});
      end
    end
    issue(0, 0, 0, 8'h20, 64'h0, 1);
    drain();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    test_reset();
    test_word_port0();
    test_byte_port1();
    test_contention();
    test_reset_mid_read();
    test_withdrawn();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit, required completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
